// File: rtl/fifo_read_ctrl_if.sv
// Read-side output stream of the async FIFO: registered word plus valid/ready handshake.
// The controller drives the master side; the consumer uses the slave side.
interface fifo_read_ctrl_if #(
    parameter int DSIZE = 6
);
    logic [DSIZE-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side controller (rclk domain): wptr synchroniser, rempty, memory read port and output register.
// Optional macro RD_LEVEL_EN builds a registered fill estimate on rd_level; without it rd_level is tied to 0.
module fifo_read_ctrl #(
    parameter int DSIZE = 6,
    parameter int ASIZE = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   wptr_gray,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [ASIZE-1:0] raddr,
    output logic             rclk_en,
    output logic             rempty,
    output logic [ASIZE:0]   rptr_gray,
    output logic [ASIZE:0]   rd_level,
    fifo_read_ctrl_if.master rd
);
    logic [ASIZE:0] wq1;
    logic [ASIZE:0] wq2;
    logic [ASIZE:0] rptr_bin;
    logic [ASIZE:0] rbin_next;
    logic [ASIZE:0] rgray_next;

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    // A pop needs a stored word and room in the output register (empty, or draining this edge).
    assign rclk_en    = !rempty && (!rd.rd_valid || rd.rd_ready);
    assign raddr      = rptr_bin[ASIZE-1:0];
    assign rbin_next  = rptr_bin + {{ASIZE{1'b0}}, rclk_en};
    assign rgray_next = bin2gray(rbin_next);

    // Two-flop synchroniser for the write pointer; nothing else samples wptr_gray.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wptr_gray;
            wq2 <= wq1;
        end
    end

    // Read pointer and empty flag; empty compares the post-pop pointer so a lagging wq2 only delays reads.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
        end else begin
            rptr_bin  <= rbin_next;
            rptr_gray <= rgray_next;
            rempty    <= (rgray_next == wq2);
        end
    end

    // Output register: load on pop, drop valid on accept without a refill, otherwise hold.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd.rd_data  <= '0;
            rd.rd_valid <= 1'b0;
        end else if (rclk_en) begin
            rd.rd_data  <= mem_rdata;
            rd.rd_valid <= 1'b1;
        end else if (rd.rd_valid && rd.rd_ready) begin
            rd.rd_valid <= 1'b0;
        end
    end

`ifdef RD_LEVEL_EN
    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Uses the synchronised write pointer, so the level lags but never over-reports.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_level <= '0;
        end else begin
            rd_level <= gray2bin(wq2) - rbin_next;
        end
    end
`else
    assign rd_level = '0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: writer model on its own clock, memory array, and a queue scoreboard.
// Compile with RD_LEVEL_EN defined to check the fill estimate instead of the tied-off level.
`timescale 1ns/1ps
module tb_fifo_read_ctrl;
    localparam int DSIZE = 6;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             rclk = 1'b0;
    logic             wclk = 1'b0;
    logic             rrst_n = 1'b1;
    logic [ASIZE:0]   wptr_gray = '0;
    logic [DSIZE-1:0] mem_rdata;
    logic [ASIZE-1:0] raddr;
    logic             rclk_en;
    logic             rempty;
    logic [ASIZE:0]   rptr_gray;
    logic [ASIZE:0]   rd_level;
    logic [DSIZE-1:0] mem [DEPTH];

    fifo_read_ctrl_if #(.DSIZE(DSIZE)) rd ();

    fifo_read_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .wptr_gray (wptr_gray),
        .mem_rdata (mem_rdata),
        .raddr     (raddr),
        .rclk_en   (rclk_en),
        .rempty    (rempty),
        .rptr_gray (rptr_gray),
        .rd_level  (rd_level),
        .rd        (rd)
    );

    assign mem_rdata = mem[raddr];

    int n_tests = 0;
    int n_fail  = 0;

    // Writer-side model state (owned by the writer process)
    int               wcount = 0;
    int               clr_ack = 0;
    logic [DSIZE-1:0] exp_data [$];
    // Control of the writer and reader-side model state (owned by the main process)
    int               clr_req = 0;
    int               whalf = 5;
    int               wtarget = 0;
    bit               wr_en = 0;
    int               pre_n = 0;
    logic [DSIZE-1:0] pre_data [3];
    int               pops = 0;
    int               acc = 0;
    bit               prev_hold = 0;
    logic [DSIZE-1:0] held = '0;

    always #15 rclk = ~rclk;
    initial begin
        #1;
        forever #(whalf) wclk = ~wclk;
    end

    function automatic logic [ASIZE:0] gray_of(input int n);
        logic [ASIZE:0] b;
        b = n[ASIZE:0];
        return b ^ (b >> 1);
    endfunction

    // Writer: fills memory in order and never lets unconsumed words exceed the depth.
    always @(posedge wclk) begin : writer
        logic [DSIZE-1:0] d;
        if (clr_ack != clr_req) begin
            wcount    = 0;
            wptr_gray = '0;
            exp_data.delete();
            clr_ack   = clr_req;
        end else if (wr_en && rrst_n && wcount < wtarget && (wcount - acc) < DEPTH) begin
            d = (wcount < pre_n) ? pre_data[wcount] : DSIZE'($urandom);
            mem[wcount[ASIZE-1:0]] = d;
            exp_data.push_back(d);
            wcount    = wcount + 1;
            wptr_gray = gray_of(wcount);
        end
    end

    task automatic do_reset();
        wr_en = 0;
        rd.rd_ready = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b0;
        clr_req++;
        for (int i = 0; i < 20 && clr_ack != clr_req; i++) @(negedge rclk);
        n_tests++;
        if (clr_ack != clr_req) begin
            n_fail++;
            $display("FAIL model_clear: ack %0d req %0d", clr_ack, clr_req);
        end
        pops = 0; acc = 0; prev_hold = 0; pre_n = 0; wtarget = 0;
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 400 && wcount < n; i++) #1;
        n_tests++;
        if (wcount != n) begin
            n_fail++;
            $display("FAIL write_count: got %0d want %0d", wcount, n);
        end
    endtask

    // One consumer cycle: check state left by the last edge, choose rd_ready, predict this edge.
    task automatic rd_cycle(input bit rdy);
        @(negedge rclk);
        n_tests++;
        if (rptr_gray !== gray_of(pops)) begin
            n_fail++;
            $display("FAIL rptr_gray: got %b want %b (pops %0d)", rptr_gray, gray_of(pops), pops);
        end
        if (prev_hold) begin
            n_tests++;
            if (rd.rd_valid !== 1'b1 || rd.rd_data !== held) begin
                n_fail++;
                $display("FAIL hold_stable: got v=%b d=%h want v=1 d=%h", rd.rd_valid, rd.rd_data, held);
            end
        end
`ifdef RD_LEVEL_EN
        n_tests++;
        if (int'(rd_level) > wcount - pops) begin
            n_fail++;
            $display("FAIL rd_level_over: got %0d want <= %0d", rd_level, wcount - pops);
        end
`else
        n_tests++;
        if (rd_level !== '0) begin
            n_fail++;
            $display("FAIL rd_level_tied: got %0d want 0", rd_level);
        end
`endif
        rd.rd_ready = rdy;
        #1;
        if (rclk_en === 1'b1) begin
            n_tests++;
            if (pops >= wcount) begin
                n_fail++;
                $display("FAIL pop_when_empty: pops %0d written %0d", pops, wcount);
            end
            pops++;
        end
        if (rd.rd_valid === 1'b1 && rdy) begin
            n_tests++;
            if (acc >= exp_data.size()) begin
                n_fail++;
                $display("FAIL extra_word: got %h with %0d expected words", rd.rd_data, exp_data.size());
            end else if (rd.rd_data !== exp_data[acc]) begin
                n_fail++;
                $display("FAIL data[%0d]: got %h want %h", acc, rd.rd_data, exp_data[acc]);
            end
            acc++;
        end
        prev_hold = (rd.rd_valid === 1'b1) && !rdy;
        held = rd.rd_data;
    endtask

    task automatic run_stream(input int n, input int wh, input bit rand_rdy);
        do_reset();
        whalf = wh; wtarget = n; wr_en = 1;
        for (int c = 0; c < 3000 && acc < n; c++) rd_cycle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        for (int c = 0; c < 4; c++) rd_cycle(1'b1);
        n_tests++;
        if (acc != n || pops != n || wcount != n) begin
            n_fail++;
            $display("FAIL stream_count: acc %0d pops %0d written %0d want %0d", acc, pops, wcount, n);
        end
        n_tests++;
        if (rd.rd_valid !== 1'b0 || rempty !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_drain: got v=%b empty=%b want v=0 empty=1", rd.rd_valid, rempty);
        end
    endtask

    task automatic test_reset();
        #2 rrst_n = 1'b0;
        #1;
        n_tests++;
        if (rempty !== 1'b1 || rd.rd_valid !== 1'b0 || rptr_gray !== '0 || rclk_en !== 1'b0 ||
            raddr !== '0 || rd.rd_data !== '0 || rd_level !== '0) begin
            n_fail++;
            $display("FAIL reset_state: empty=%b v=%b gray=%b en=%b addr=%h d=%h lvl=%0d", rempty,
                     rd.rd_valid, rptr_gray, rclk_en, raddr, rd.rd_data, rd_level);
        end
        do_reset();
        whalf = 5; wtarget = 30; wr_en = 1;
        for (int c = 0; c < 200 && acc < 6; c++) rd_cycle(1'b1);
        wr_en = 0;
        #4;
        n_tests++;
        if (rd.rd_valid !== 1'b1 || rptr_gray === '0) begin
            n_fail++;
            $display("FAIL pre_reset_active: got v=%b gray=%b want v=1 gray!=0", rd.rd_valid, rptr_gray);
        end
        rrst_n = 1'b0;
        #1;
        n_tests++;
        if (rempty !== 1'b1 || rd.rd_valid !== 1'b0 || rptr_gray !== '0 || rclk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: empty=%b v=%b gray=%b en=%b want 1 0 0 0", rempty, rd.rd_valid,
                     rptr_gray, rclk_en);
        end
    endtask

    task automatic test_single();
        do_reset();
        rd.rd_ready = 1'b1;
        pre_data[0] = 6'h2A; pre_n = 1; whalf = 5; wtarget = 1; wr_en = 1;
        wait_writes(1);
        for (int e = 1; e <= 4; e++) begin
            @(posedge rclk); #1;
            n_tests++;
            if (e < 4 && (rd.rd_valid !== 1'b0 || rempty !== (e < 3))) begin
                n_fail++;
                $display("FAIL latency_E%0d: got v=%b empty=%b want v=0 empty=%b", e, rd.rd_valid,
                         rempty, e < 3);
            end else if (e == 4 && (rd.rd_valid !== 1'b1 || rd.rd_data !== 6'h2A ||
                                    rempty !== 1'b1 || rptr_gray !== 5'b00001)) begin
                n_fail++;
                $display("FAIL single_E4: got v=%b d=%h empty=%b gray=%b want 1 2a 1 00001",
                         rd.rd_valid, rd.rd_data, rempty, rptr_gray);
            end
        end
        @(posedge rclk); #1;
        n_tests++;
        if (rd.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: got v=%b want 0", rd.rd_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [DSIZE-1:0] want;
        do_reset();
        pre_data[0] = 6'h01; pre_data[1] = 6'h02; pre_data[2] = 6'h03; pre_n = 3;
        whalf = 5; wtarget = 3; wr_en = 1;
        wait_writes(3);
        for (int c = 0; c < 10; c++) @(negedge rclk);
        n_tests++;
        if (rd.rd_valid !== 1'b1 || rd.rd_data !== 6'h01 || rclk_en !== 1'b0 ||
            rptr_gray !== gray_of(1) || rempty !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_state: v=%b d=%h en=%b gray=%b empty=%b want 1 01 0 %b 0",
                     rd.rd_valid, rd.rd_data, rclk_en, rptr_gray, rempty, gray_of(1));
        end
        rd.rd_ready = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge rclk); #1;
            want = DSIZE'(e + 1);
            n_tests++;
            if (e < 3 && (rd.rd_valid !== 1'b1 || rd.rd_data !== want)) begin
                n_fail++;
                $display("FAIL drain_E%0d: got v=%b d=%h want v=1 d=%h", e, rd.rd_valid, rd.rd_data, want);
            end else if (e == 3 && (rd.rd_valid !== 1'b0 || rempty !== 1'b1 || rptr_gray !== gray_of(3))) begin
                n_fail++;
                $display("FAIL drain_end: got v=%b empty=%b gray=%b want 0 1 %b", rd.rd_valid,
                         rempty, rptr_gray, gray_of(3));
            end
        end
    endtask

    task automatic test_level();
        do_reset();
        whalf = 5; wtarget = 5; wr_en = 1;
        wait_writes(5);
        for (int c = 0; c < 10; c++) @(negedge rclk);
        n_tests++;
`ifdef RD_LEVEL_EN
        if (rd_level !== 5'd4 || rd.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_level_settle: got %0d v=%b want 4 v=1", rd_level, rd.rd_valid);
        end
`else
        if (rd_level !== '0 || rd.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_level_off: got %0d v=%b want 0 v=1", rd_level, rd.rd_valid);
        end
`endif
    endtask

    initial begin
        rd.rd_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        run_stream(40, 5, 1'b0);
        run_stream(200, 5, 1'b1);
        run_stream(200, 45, 1'b1);
        test_level();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
